// File: rtl/store_unit_pkg.sv
// Shared types for the store unit: size codes, buffered-entry layout and beat-FSM states.
package store_unit_pkg;

    localparam logic [2:0] MEM_BYTE = 3'b000;
    localparam logic [2:0] MEM_HALF = 3'b001;
    localparam logic [2:0] MEM_WORD = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data64;
        logic [7:0]  strb8;
    } store_entry_t;

    typedef enum logic [1:0] {
        BEAT_IDLE = 2'd0,
        BEAT_0    = 2'd1,
        BEAT_1    = 2'd2
    } beat_state_e;

    // Unsupported size codes yield an empty strobe, which marks the store as discarded.
    function automatic logic [3:0] base_strb(input logic [2:0] func3);
        case (func3)
            MEM_BYTE: base_strb = 4'b0001;
            MEM_HALF: base_strb = 4'b0011;
            MEM_WORD: base_strb = 4'b1111;
            default:  base_strb = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Core-side store request and memory-side write beat bundle of the store unit.
interface store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_func3;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        misalign_err;
    logic        buf_empty;

    modport master (
        output req_valid, req_addr, req_data, req_func3, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, misalign_err, buf_empty
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_func3, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, misalign_err, buf_empty
    );

endinterface

// File: rtl/store_unit_align.sv
// Combinational lane alignment: 8-bit strobe S and 64-bit data D for a store at byte offset off.
module store_align
    import store_unit_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_data,
    output logic [7:0]  o_strb8,
    output logic [63:0] o_data64
);

    logic [7:0] w_base;

    assign w_base   = {4'b0000, base_strb(i_func3)};
    assign o_strb8  = w_base << i_off;
    assign o_data64 = {32'd0, i_data} << {i_off, 3'b000};

endmodule

// File: rtl/store_unit.sv
// Store buffer with a beat FSM issuing lane-aligned writes to memory.
// STORE_MISALIGN_SPLIT_EN: word-crossing stores issue as two beats instead of being dropped.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic       clk,
    input  logic       rst_n,
    store_unit_if.slave bus
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0]      S_IDLE   = BEAT_IDLE;
    localparam logic [1:0]      S_BEAT0  = BEAT_0;
    localparam logic [1:0]      S_BEAT1  = BEAT_1;

    store_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [PTR_W:0]     w_count_next;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_misalign;

    logic [7:0]         w_strb8;
    logic [63:0]        w_data64;
    logic               w_accept;
    logic               w_cross_in;
    logic               w_push;
    logic               w_drop_cross;
    logic               w_hs;
    logic               w_pop;
    logic               w_head_cross;
    store_entry_t       w_head;
    store_entry_t       w_new_entry;

    store_align u_align (
        .i_func3  (bus.req_func3),
        .i_off    (bus.req_addr[1:0]),
        .i_data   (bus.req_data),
        .o_strb8  (w_strb8),
        .o_data64 (w_data64)
    );

    assign bus.req_ready = (r_count != FULL_CNT);
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_cross_in    = (w_strb8[7:4] != 4'b0000);

`ifdef STORE_MISALIGN_SPLIT_EN
    assign w_push       = w_accept && (w_strb8 != 8'd0);
    assign w_drop_cross = 1'b0;
`else
    assign w_push       = w_accept && (w_strb8 != 8'd0) && !w_cross_in;
    assign w_drop_cross = w_accept && w_cross_in;
`endif

    assign w_new_entry = '{addr: {bus.req_addr[31:2], 2'b00}, data64: w_data64, strb8: w_strb8};

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_cross = (w_head.strb8[7:4] != 4'b0000);

    assign bus.mem_valid    = (r_state != S_IDLE);
    assign bus.mem_addr     = (r_state == S_BEAT1) ? (w_head.addr + 32'd4) : w_head.addr;
    assign bus.mem_wdata    = (r_state == S_BEAT1) ? w_head.data64[63:32] : w_head.data64[31:0];
    assign bus.mem_wstrb    = (r_state == S_BEAT0) ? w_head.strb8[3:0] :
                              (r_state == S_BEAT1) ? w_head.strb8[7:4] : 4'b0000;
    assign bus.misalign_err = r_misalign;
    assign bus.buf_empty    = (r_count == '0);

    // An entry leaves the buffer only with its final beat.
    assign w_hs  = bus.mem_valid && bus.mem_ready;
    assign w_pop = w_hs && ((r_state == S_BEAT1) || !w_head_cross);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) w_state_next = S_BEAT0;
            end
            S_BEAT0: begin
                if (w_hs) begin
                    if (w_head_cross)            w_state_next = S_BEAT1;
                    else if (w_count_next != '0) w_state_next = S_BEAT0;
                    else                         w_state_next = S_IDLE;
                end
            end
            S_BEAT1: begin
                if (w_hs) w_state_next = (w_count_next != '0) ? S_BEAT0 : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_misalign <= w_drop_cross;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_new_entry;
    end

endmodule
